// File: rtl/mul_pkg.sv
// mul_pkg
// Shared definitions for the iterative multiplier slice.
//   mul_op_t    : requested product word / operand signedness
//   mul_state_t : control states of mul_iter_unit
//   MUL_ITER    : number of shift-add iterations (one per multiplier bit)
package mul_pkg;

  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/shift_expander.sv
// shift_expander
// Zero-extends a 32-bit value to 64 bits and shifts it left, producing one
// partial product of the shift-add multiplier.
//   data_in  [31:0] : multiplicand magnitude
//   shift    [6:0]  : left shift amount
//   data_out [63:0] : {32'b0, data_in} << shift (64-bit modulo)
module shift_expander (
  input  logic [31:0] data_in,
  input  logic [6:0]  shift,
  output logic [63:0] data_out
);

  assign data_out = {32'b0, data_in} << shift;

endmodule

// File: rtl/mul_iter_unit.sv
// mul_iter_unit
// Fixed-latency iterative 32x32 multiplier (RISC-V M-extension style).
// Operands are reduced to magnitudes, multiplied unsigned with one shift-add
// per multiplier bit, and the sign is restored in a final cycle.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/in_ready: request handshake (in_ready only while IDLE)
//   in_op [1:0]      : MUL / MULH / MULHSU / MULHU
//   in_a, in_b [31:0]: rs1, rs2
//   flush            : abort any operation, return to IDLE next edge
//   out_valid/out_ready: result handshake (out_valid only while DONE)
//   out_result [31:0]: low word for MUL, high word otherwise
module mul_iter_unit
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);

  mul_state_t  state;
  mul_op_t     op_q;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        neg_q;
  logic [4:0]  cnt;
  logic        last;
  logic [63:0] acc;
  logic [63:0] product;

  logic        a_signed;
  logic        b_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        neg_in;
  logic [63:0] partial;

  // Operand conditioning for an incoming request. The magnitude of
  // 0x80000000 wraps back to 0x80000000, which is exactly right when the
  // value is read as unsigned 32 bits.
  always_comb begin
    a_signed = (in_op == MULH) || (in_op == MULHSU);
    b_signed = (in_op == MULH);
    abs_a    = (a_signed && in_a[31]) ? -in_a : in_a;
    abs_b    = (b_signed && in_b[31]) ? -in_b : in_b;
    neg_in   = (a_signed & in_a[31]) ^ (b_signed & in_b[31]);
  end

  shift_expander u_shift_expander (
    .data_in  (mag_a),
    .shift    ({2'b00, cnt}),
    .data_out (partial)
  );

  // Control and datapath. BUSY runs 32 accumulate cycles (counter 0..31),
  // then one extra cycle that applies the sign to the finished magnitude, so
  // the result appears 33 edges after acceptance whatever the operands are.
  // Flush wins over every handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= MUL;
      mag_a   <= '0;
      mag_b   <= '0;
      neg_q   <= 1'b0;
      cnt     <= '0;
      last    <= 1'b0;
      acc     <= '0;
      product <= '0;
    end else if (flush) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 1'b0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= mul_op_t'(in_op);
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg_q <= neg_in;
            acc   <= '0;
            cnt   <= '0;
            last  <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (last) begin
            product <= neg_q ? -acc : acc;
            last    <= 1'b0;
            state   <= DONE;
          end else begin
            if (mag_b[cnt]) begin
              acc <= acc + partial;
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'(MUL_ITER - 1)) begin
              last <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = (op_q == MUL) ? product[31:0] : product[63:32];

endmodule

// File: tb/tb_mul_iter_unit.sv
// tb_mul_iter_unit
// Self-checking bench for mul_iter_unit: a cycle-level reference model built
// from plain 64-bit arithmetic, a per-cycle compare process, and directed
// vectors with hand-computed results.
module tb_mul_iter_unit;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;
  localparam int LATENCY = 33;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int compared;
  int mismatched;

  mul_iter_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point; every check goes through here.
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product word computed directly from the operand semantics.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] xb;
    logic [63:0] p;
    xa = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
    xb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Cycle-level model: a pending request counts down its fixed latency, then
  // the result is held until consumed; flush or reset abandon everything.
  int          m_wait;
  bit          m_done;
  logic [31:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait = 0;
      m_done = 0;
      m_res  = '0;
    end else if (flush) begin
      m_wait = 0;
      m_done = 0;
    end else if (m_done) begin
      if (out_ready) m_done = 0;
    end else if (m_wait > 0) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) m_done = 1;
    end else if (in_valid) begin
      m_wait = LATENCY;
      m_res  = ref_mul(in_op, in_a, in_b);
    end
  end

  // Compare process on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      cmp("rst_in_ready", in_ready, 1'b1);
      cmp("rst_out_valid", out_valid, 1'b0);
      cmp("rst_out_result", out_result, 32'h0);
    end else begin
      cmp("in_ready", in_ready, (!m_done && m_wait == 0));
      cmp("out_valid", out_valid, m_done);
      if (m_done) cmp("out_result", out_result, m_res);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] exp);
    cmp({name, "_result"}, out_result, exp);
    cmp({name, "_model"}, m_res, exp);
  endtask

  // Issue one request, measure latency, check the result, optionally stall
  // the consumer for hold cycles, then confirm return to IDLE.
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input int hold);
    int k;
    @(negedge clk);
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    cmp({name, "_accept_ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    cmp({name, "_latency"}, k, LATENCY);
    checkOutput(name, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      cmp({name, "_hold_result"}, out_result, exp);
      cmp({name, "_hold_in_ready"}, in_ready, 1'b0);
      cmp({name, "_hold_valid"}, out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cmp({name, "_drain_valid"}, out_valid, 1'b0);
    cmp({name, "_drain_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = OP_MUL;
    in_a       = '0;
    in_b       = '0;
    flush      = 1'b0;
    out_ready  = 1'b1;

    #3;
    cmp("reset_in_ready", in_ready, 1'b1);
    cmp("reset_out_valid", out_valid, 1'b0);
    cmp("reset_out_result", out_result, 32'h0);

    cmp("pin_mulhu", ref_mul(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    cmp("pin_mulhsu", ref_mul(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    cmp("pin_mulh", ref_mul(OP_MULH, 32'h80000000, 32'h80000000), 32'h40000000);

    #19 rst_n = 1'b1;

    applyStimulus("mulhu_max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    applyStimulus("mul_max", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
    applyStimulus("mulh_min", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    applyStimulus("mulhsu_m1", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    applyStimulus("mul_x3", OP_MUL, 32'h3AE51959, 32'h00000003, 32'hB0AF4C0B, 0);
    applyStimulus("mul_zero", OP_MUL, 32'h3AE51959, 32'h00000000, 32'h00000000, 0);
    applyStimulus("mulh_neg2", OP_MULH, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0);
    applyStimulus("mulh_pmax", OP_MULH, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 0);
    applyStimulus("mul_stall", OP_MUL, 32'h3AE51959, 32'h00000003, 32'hB0AF4C0B, 5);

    // Flush ten cycles into BUSY: the operation must vanish.
    @(negedge clk);
    in_op    = OP_MUL;
    in_a     = 32'h12345678;
    in_b     = 32'h00000009;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    cmp("flush_in_ready", in_ready, 1'b1);
    cmp("flush_out_valid", out_valid, 1'b0);
    repeat (40) @(posedge clk);
    applyStimulus("post_flush_mulhu", OP_MULHU, 32'd2, 32'd3, 32'h00000000, 0);
    applyStimulus("post_flush_mul", OP_MUL, 32'd2, 32'd3, 32'h00000006, 0);

    // Asynchronous reset pulse mid-BUSY, between clock edges.
    @(negedge clk);
    in_op    = OP_MULHU;
    in_a     = 32'hDEADBEEF;
    in_b     = 32'hCAFEF00D;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_in_ready", in_ready, 1'b1);
    cmp("async_rst_out_valid", out_valid, 1'b0);
    cmp("async_rst_out_result", out_result, 32'h0);
    #4 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    applyStimulus("post_reset_mul", OP_MUL, 32'h00010001, 32'h00010001, 32'h00020001, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
